arb4_rr: RTL and testbench

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_rr_pkg.sv | 23 ++
 rtl/tmux4_1.sv | 17 +
 rtl/arb4_rr.sv | 77 +++++++
 tb/tb_arb4_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb4_rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encodings,
// requester count and the rotating priority pick.
package arb4_rr_pkg;

  localparam int NREQ = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Returns {found, index}; searches ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Walking backwards lets the closest-to-ptr requester overwrite the rest.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/tmux4_1.sv
// One-hot 4:1 AND-OR data mux; output is zero when no select bit is set.
module tmux4_1 #(
  parameter int DW = 32
) (
  input  logic [3:0]      sel,
  input  logic [4*DW-1:0] din,
  output logic [DW-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout = dout | (din[i*DW +: DW] & {DW{sel[i]}});
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with a registered one-hot grant and
// back-to-back handoff on downstream acceptance.
module arb4_rr
  import arb4_rr_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id
);

  logic       state;
  logic [1:0] ptr;
  logic [1:0] ptr_next;
  logic       fire;
  logic [2:0] idle_pick;
  logic [2:0] next_pick;
  logic [DW-1:0] mux_data;

  assign fire      = (state == ST_BUSY) && out_ready;
  assign ptr_next  = out_id + 2'd1;
  assign idle_pick = rr_pick(req, ptr);
  // The finishing requester is masked so a still-high req cannot regrab.
  assign next_pick = rr_pick(req & ~gnt, ptr_next);

  assign out_valid = (state == ST_BUSY);
  assign ack       = (fire && resetn) ? gnt : 4'b0000;

  tmux4_1 #(.DW(DW)) u_mux (
    .sel  (gnt),
    .din  (req_data),
    .dout (mux_data)
  );

  assign out_data = resetn ? mux_data : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      gnt    <= 4'b0000;
      out_id <= 2'd0;
      ptr    <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idle_pick[2]) begin
            state  <= ST_BUSY;
            gnt    <= 4'b0001 << idle_pick[1:0];
            out_id <= idle_pick[1:0];
          end
        end
        default: begin
          if (fire) begin
            ptr <= ptr_next;
            if (next_pick[2]) begin
              gnt    <= 4'b0001 << next_pick[1:0];
              out_id <= next_pick[1:0];
            end else begin
              state  <= ST_IDLE;
              gnt    <= 4'b0000;
              out_id <= 2'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr: inputs change on the falling edge, outputs are
// checked 1ns later against hand-computed values.
module tb_arb4_rr;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [3:0]      req = 4'b0000;
  logic [4*DW-1:0] req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arb4_rr #(.DW(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++;
    if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
    tests_run++;
    if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h want 00", out_data); end
    resetn = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL reset_first_gnt: got %b want 0001", gnt); end
    tests_run++;
    if (out_data !== 8'hA0) begin fails++; $display("[TB] FAIL reset_first_data: got %h want a0", out_data); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (gnt !== exp_gnt[i]) begin fails++; $display("[TB] FAIL rotation_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
      tests_run++;
      if (ack !== exp_gnt[i]) begin fails++; $display("[TB] FAIL rotation_ack[%0d]: got %b want %b", i, ack, exp_gnt[i]); end
      tests_run++;
      if (out_id !== exp_id[i]) begin fails++; $display("[TB] FAIL rotation_id[%0d]: got %0d want %0d", i, out_id, exp_id[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0100;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) req = 4'b1111;
      #1;
      tests_run++;
      if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL bp_gnt[%0d]: got %b want 0100", i, gnt); end
      tests_run++;
      if (out_data !== 8'hC2) begin fails++; $display("[TB] FAIL bp_data[%0d]: got %h want c2", i, out_data); end
      tests_run++;
      if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL bp_ack[%0d]: got %b want 0000", i, ack); end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (ack !== 4'b0100) begin fails++; $display("[TB] FAIL bp_fire_ack: got %b want 0100", ack); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL bp_ack_once: got %b want 0000", ack); end
    tests_run++;
    if (gnt !== 4'b1000) begin fails++; $display("[TB] FAIL bp_next_gnt: got %b want 1000", gnt); end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    req = 4'b1001;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (ack !== 4'b0001) begin fails++; $display("[TB] FAIL fair_ack0: got %b want 0001", ack); end
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b1000) begin fails++; $display("[TB] FAIL fair_gnt3: got %b want 1000", gnt); end
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL fair_gnt0: got %b want 0001", gnt); end
  endtask

  task automatic test_idle_return();
    do_reset();
    req = 4'b0010;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (ack !== 4'b0010) begin fails++; $display("[TB] FAIL idle_ack: got %b want 0010", ack); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL idle_gnt: got %b want 0000", gnt); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL idle_data: got %h want 00", out_data); end
    @(negedge clk);
    req = 4'b0010;
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL idle_stay: got %b want 0000", gnt); end
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0010) begin fails++; $display("[TB] FAIL idle_regrant: got %b want 0010", gnt); end
    tests_run++;
    if (out_id !== 2'd1) begin fails++; $display("[TB] FAIL idle_regrant_id: got %0d want 1", out_id); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b1000;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (out_id !== 2'd3) begin fails++; $display("[TB] FAIL midrst_id: got %0d want 3", out_id); end
    resetn = 1'b0;
    out_ready = 1'b1;
    req = 4'b1111;
    #1;
    tests_run++;
    if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL midrst_ack: got %b want 0000", ack); end
    tests_run++;
    if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL midrst_data: got %h want 00", out_data); end
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL midrst_gnt: got %b want 0000", gnt); end
    resetn = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin fails++; $display("[TB] FAIL midrst_prio: got %b want 0001", gnt); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_fairness();
    test_idle_return();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
